td4_prog_loader: RTL and testbench
==================================

Name: td4_prog_loader

Overview:
- Program loader directly upstream of the TD4 instruction memory.
- Receives 8-bit instruction words (opcode + immediate) from asynchronous pins using a level "load enable" and a per-word strobe.
- Writes the words to consecutive memory addresses from 0, with auto-increment.
- Holds the CPU in reset while loading, plus a fixed release delay after loading ends.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W words.
- SYNC_STAGES, 2, flip-flop stages in each pin synchronizer (minimum 2).
- RELEASE_CYCLES, 4, cycles the CPU hold stays asserted after load_en deasserts (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset. Asserts immediately; deassertion is synchronous to clk.
- load_en  in  1  asynchronous level from pin; high = loading session.
- strobe  in  1  asynchronous pin; each rising edge delivers one word.
- data_in  in  8  {immediate[7:4], opcode[3:0]}. Must be stable from strobe rise to strobe fall.
- mem_we  out  1  one-cycle write pulse to memory; active high.
- mem_addr  out  ADDR_W  write address.
- mem_opcode  out  4  opcode written.
- mem_imm  out  4  immediate written.
- cpu_hold  out  1  high = CPU held in reset; top ANDs ~cpu_hold into the CPU rst_n.
- busy  out  1  high in any state other than IDLE.
- count  out  ADDR_W+1  words written in the current/last session, 0..2**ADDR_W.
- overflow  out  1  sticky; a strobe arrived while memory was full.

Behaviour:
- Reset values: state IDLE; mem_we 0; mem_addr 0; mem_opcode 0; mem_imm 0; cpu_hold 0; busy 0; count 0; overflow 0. Synchronizer flops are cleared to 0.
- All outputs are registered. No combinational path from input pins to outputs.
- load_en and strobe each pass through a SYNC_STAGES flop chain.
- strobe_rise = synchronized strobe high AND previous synchronized value low. This is a single-cycle pulse.
- data_in is captured in the cycle strobe_rise is high. It is not synchronized; the stability requirement above makes this safe.

State machine:
- IDLE: cpu_hold 0.
  - If sync load_en = 1: go to LOAD. Set mem_addr 0, count 0, overflow 0, cpu_hold 1.
- LOAD: cpu_hold 1.
  - On strobe_rise with count < depth: capture data_in into mem_opcode/mem_imm, go to WRITE.
  - On strobe_rise with count = depth: set overflow 1, stay in LOAD; memory is not written.
  - If sync load_en = 0 and no strobe_rise this cycle: go to RELEASE, load the release counter with RELEASE_CYCLES.
- WRITE: exactly one cycle with mem_we = 1, using mem_addr and the captured data.
  - Next cycle: mem_addr increments modulo depth (wraps to 0 after the last address), count += 1, back to LOAD.
  - load_en falling during WRITE is ignored; the write always completes and LOAD then sees load_en low.
- RELEASE: cpu_hold 1.
  - The counter decrements every cycle. When it reaches 0: go to IDLE, cpu_hold 0.
  - If load_en returns high before the counter expires: go straight to LOAD with addr/count cleared (new session).
- Timing: latency from strobe_rise to mem_we is 1 cycle. Strobe edges may arrive as often as every 2 cycles without being lost.
- count is never cleared on exit. It holds the last session's total until the next LOAD entry.
- A strobe while IDLE or RELEASE is ignored and does not set overflow.
- Reset mid-load aborts with no write pulse. Any partially loaded memory contents stay as written.

Decomposition:
- Shared package td4_pkg:
  - state enum: IDLE, LOAD, WRITE, RELEASE.
  - constants: OPCODE_W = 4, IMM_W = 4.
  - default ADDR_W.
- Sub-module: td4_sync_edge. It is an N-stage synchronizer with a rising-edge output, instantiated for strobe; load_en uses its level output only.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0; strobe pulses produce no mem_we.
- load_en high, 3 strobes with data 0x3B, 0x01, 0xF0 → mem_we pulses at addr 0,1,2 with (op,imm) = (B,3),(1,0),(0,F); count 3. load_en low → cpu_hold stays high 4 cycles, then 0; busy 0.
- 17 strobes in one session → 16 writes at addr 0..15; 17th produces no mem_we and sets overflow 1; count 16; next session clears overflow.
- Strobe edges every 2 cycles (1 high, 1 low synchronized) → no word lost; count equals number of edges.
- load_en falls in the same cycle as WRITE → write at the correct address completes, then RELEASE.
- rst_n low mid-session after 5 words → outputs return to reset values immediately; after reset, no mem_we until a new load_en session.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader.
// The state enum, word field widths and the default address width live here.
package td4_pkg;

    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned IMM_W      = 4;
    localparam int unsigned WORD_W     = OPCODE_W + IMM_W;
    localparam int unsigned DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Pin word layout: immediate in the upper nibble, opcode in the lower nibble.
    typedef struct packed {
        logic [IMM_W-1:0]    imm;
        logic [OPCODE_W-1:0] opcode;
    } word_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Loader bus: programming pins in, instruction-memory write port and status out.
// The slave modport is the loader's view; master is the host/memory side.
interface td4_prog_loader_if
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic                load_en;
    logic                strobe;
    logic [WORD_W-1:0]   data_in;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [OPCODE_W-1:0] mem_opcode;
    logic [IMM_W-1:0]    mem_imm;
    logic                cpu_hold;
    logic                busy;
    logic [ADDR_W:0]     count;
    logic                overflow;

    modport slave (
        input  load_en, strobe, data_in,
        output mem_we, mem_addr, mem_opcode, mem_imm,
        output cpu_hold, busy, count, overflow
    );

    modport master (
        output load_en, strobe, data_in,
        input  mem_we, mem_addr, mem_opcode, mem_imm,
        input  cpu_hold, busy, count, overflow
    );

endinterface

// File: rtl/td4_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with a registered level output
// and a single-cycle rising-edge pulse derived from the synchronized level.
module td4_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/td4_prog_loader.sv
// Program loader for the TD4 instruction memory: writes strobed pin words to
// consecutive addresses and holds the CPU in reset during and shortly after loading.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    td4_prog_loader_if.slave   bus
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);

    logic load_en_sync;
    logic strobe_rise_c;
    logic unused_load_en_rise_c;
    logic unused_strobe_level;

    td4_sync_edge #(.STAGES(SYNC_STAGES)) u_load_en_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (bus.load_en),
        .level  (load_en_sync),
        .rise_c (unused_load_en_rise_c)
    );

    td4_sync_edge #(.STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (bus.strobe),
        .level  (unused_strobe_level),
        .rise_c (strobe_rise_c)
    );

    // data_in is sampled raw; the pin protocol keeps it stable across the capture cycle.
    word_t word_c;
    assign word_c = word_t'(bus.data_in);

    state_t              state,      state_n;
    logic                mem_we,     mem_we_n;
    logic [ADDR_W-1:0]   mem_addr,   mem_addr_n;
    logic [OPCODE_W-1:0] mem_opcode, mem_opcode_n;
    logic [IMM_W-1:0]    mem_imm,    mem_imm_n;
    logic                cpu_hold,   cpu_hold_n;
    logic                busy,       busy_n;
    logic [CNT_W-1:0]    count,      count_n;
    logic                overflow,   overflow_n;
    logic [REL_W-1:0]    rel_cnt,    rel_cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_opcode <= '0;
            mem_imm    <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            rel_cnt    <= '0;
        end else begin
            state      <= state_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_opcode <= mem_opcode_n;
            mem_imm    <= mem_imm_n;
            cpu_hold   <= cpu_hold_n;
            busy       <= busy_n;
            count      <= count_n;
            overflow   <= overflow_n;
            rel_cnt    <= rel_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_opcode_n = mem_opcode;
        mem_imm_n    = mem_imm;
        cpu_hold_n   = cpu_hold;
        count_n      = count;
        overflow_n   = overflow;
        rel_cnt_n    = rel_cnt;

        unique case (state)
            IDLE: begin
                cpu_hold_n = 1'b0;
                if (load_en_sync) begin
                    state_n    = LOAD;
                    mem_addr_n = '0;
                    count_n    = '0;
                    overflow_n = 1'b0;
                    cpu_hold_n = 1'b1;
                end
            end
            LOAD: begin
                cpu_hold_n = 1'b1;
                // A strobe edge takes priority over a simultaneous load_en drop.
                if (strobe_rise_c) begin
                    if (count < CNT_W'(DEPTH)) begin
                        state_n      = WRITE;
                        mem_we_n     = 1'b1;
                        mem_opcode_n = word_c.opcode;
                        mem_imm_n    = word_c.imm;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end else if (!load_en_sync) begin
                    state_n   = RELEASE;
                    rel_cnt_n = REL_W'(RELEASE_CYCLES);
                end
            end
            WRITE: begin
                state_n    = LOAD;
                mem_addr_n = mem_addr + ADDR_W'(1);
                count_n    = count + CNT_W'(1);
            end
            RELEASE: begin
                if (load_en_sync) begin
                    state_n    = LOAD;
                    mem_addr_n = '0;
                    count_n    = '0;
                    overflow_n = 1'b0;
                    cpu_hold_n = 1'b1;
                    rel_cnt_n  = '0;
                end else if (rel_cnt <= REL_W'(1)) begin
                    state_n    = IDLE;
                    cpu_hold_n = 1'b0;
                    rel_cnt_n  = '0;
                end else begin
                    rel_cnt_n = rel_cnt - REL_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_opcode = mem_opcode;
    assign bus.mem_imm    = mem_imm;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.busy       = busy;
    assign bus.count      = count;
    assign bus.overflow   = overflow;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: randomized program sessions checked
// against a per-session list of expected memory writes.
module tb_td4_prog_loader;
    import td4_pkg::*;

    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned RELEASE_CYCLES = 4;
    localparam int unsigned DEPTH          = 1 << ADDR_W;
    localparam int          HOLD_LAT       = SYNC_STAGES + 1 + RELEASE_CYCLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    td4_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    td4_prog_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_STAGES    (SYNC_STAGES),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        op;
        logic [3:0]        imm;
    } wr_t;

    wr_t obs[$];
    int  checks = 0;
    int  passes = 0;

    // Record every write pulse seen on the memory port.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1)
            obs.push_back({bus.mem_addr, bus.mem_opcode, bus.mem_imm});
    end

    // Reference: the i-th word of a session lands at address i with the nibbles split.
    function automatic wr_t model_write(input int idx, input logic [7:0] d);
        wr_t w;
        w.addr = ADDR_W'(idx % DEPTH);
        w.op   = d[3:0];
        w.imm  = d[7:4];
        return w;
    endfunction

    function automatic int model_count(input int n);
        return (n > int'(DEPTH)) ? int'(DEPTH) : n;
    endfunction

    task automatic send_word(input logic [7:0] d, input int hi, input int lo);
        @(negedge clk);
        bus.data_in = d;
        bus.strobe  = 1'b1;
        repeat (hi) @(negedge clk);
        bus.strobe  = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic start_session();
        @(negedge clk);
        bus.load_en = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        obs.delete();
    endtask

    task automatic end_session(output int cyc);
        @(negedge clk);
        bus.load_en = 1'b0;
        cyc = 0;
        while (bus.cpu_hold !== 1'b0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_opcode, bus.mem_imm, bus.cpu_hold,
             bus.busy, bus.count, bus.overflow} !== '0)
            $display("FAIL reset_outputs: got we=%b addr=%0d op=%h imm=%h hold=%b busy=%b cnt=%0d ovf=%b, want all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_opcode, bus.mem_imm, bus.cpu_hold,
                     bus.busy, bus.count, bus.overflow);
        else passes++;
        obs.delete();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            send_word(d, 3, 3);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (obs.size() != 0) $display("FAIL idle_strobe_writes: got %0d writes, want 0", obs.size());
        else passes++;
        checks++;
        if ({bus.busy, bus.cpu_hold, bus.overflow, bus.count} !== '0)
            $display("FAIL idle_strobe_state: busy=%b hold=%b ovf=%b cnt=%0d, want 0", bus.busy,
                     bus.cpu_hold, bus.overflow, bus.count);
        else passes++;
    endtask

    task automatic run_words(input logic [7:0] data[$], input int hi, input int lo, input string tag);
        int n;
        n = data.size();
        for (int i = 0; i < n; i++) send_word(data[i], hi, lo);
        repeat (8) @(negedge clk);
        checks++;
        if (obs.size() != model_count(n))
            $display("FAIL %s_nwrites: got %0d, want %0d", tag, obs.size(), model_count(n));
        else passes++;
        for (int i = 0; i < obs.size() && i < model_count(n); i++) begin
            checks++;
            if (obs[i] !== model_write(i, data[i]))
                $display("FAIL %s_write[%0d]: got %h, want %h", tag, i, obs[i], model_write(i, data[i]));
            else passes++;
        end
        checks++;
        if (bus.count !== (ADDR_W+1)'(model_count(n)))
            $display("FAIL %s_count: got %0d, want %0d", tag, bus.count, model_count(n));
        else passes++;
        checks++;
        if (bus.overflow !== (n > int'(DEPTH)))
            $display("FAIL %s_overflow: got %b, want %b", tag, bus.overflow, n > int'(DEPTH));
        else passes++;
    endtask

    task automatic test_basic_load();
        logic [7:0] data[$];
        int cyc;
        start_session();
        checks++;
        if ({bus.cpu_hold, bus.busy, bus.overflow, bus.count} !== {1'b1, 1'b1, 1'b0, 5'd0})
            $display("FAIL load_entry: hold=%b busy=%b ovf=%b cnt=%0d, want 1 1 0 0",
                     bus.cpu_hold, bus.busy, bus.overflow, bus.count);
        else passes++;
        data = '{8'h3B, 8'h01, 8'hF0};
        run_words(data, 3, 3, "basic");
        end_session(cyc);
        checks++;
        if (cyc != HOLD_LAT) $display("FAIL basic_hold_cycles: got %0d, want %0d", cyc, HOLD_LAT);
        else passes++;
        checks++;
        if ({bus.busy, bus.count} !== {1'b0, 5'd3})
            $display("FAIL basic_after_release: busy=%b cnt=%0d, want 0 3", bus.busy, bus.count);
        else passes++;
    endtask

    task automatic test_random_session();
        logic [7:0] data[$];
        int n, cyc;
        for (int s = 0; s < 3; s++) begin
            data.delete();
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) data.push_back(8'($urandom));
            start_session();
            run_words(data, $urandom_range(2, 4), $urandom_range(2, 4), "random");
            end_session(cyc);
            checks++;
            if (cyc != HOLD_LAT) $display("FAIL random_hold_cycles: got %0d, want %0d", cyc, HOLD_LAT);
            else passes++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] data[$];
        int cyc;
        for (int i = 0; i < int'(DEPTH) + 1; i++) data.push_back(8'($urandom));
        start_session();
        run_words(data, 3, 3, "overflow");
        end_session(cyc);
        checks++;
        if ({bus.overflow, bus.count} !== {1'b1, 5'(DEPTH)})
            $display("FAIL overflow_sticky: ovf=%b cnt=%0d, want 1 %0d", bus.overflow, bus.count, DEPTH);
        else passes++;
        start_session();
        checks++;
        if ({bus.overflow, bus.count, bus.mem_addr} !== '0)
            $display("FAIL overflow_cleared: ovf=%b cnt=%0d addr=%0d, want 0 0 0",
                     bus.overflow, bus.count, bus.mem_addr);
        else passes++;
        end_session(cyc);
    endtask

    task automatic test_back_to_back();
        logic [7:0] data[$];
        logic [7:0] d;
        int n, cyc;
        d = 8'($urandom);
        n = $urandom_range(4, 12);
        for (int i = 0; i < n; i++) data.push_back(d);
        bus.data_in = d;
        start_session();
        run_words(data, 1, 0, "b2b");
        end_session(cyc);
        checks++;
        if (cyc != HOLD_LAT) $display("FAIL b2b_hold_cycles: got %0d, want %0d", cyc, HOLD_LAT);
        else passes++;
    endtask

    task automatic test_load_en_fall_in_write();
        logic [7:0] data[$];
        logic [7:0] d;
        int k, cyc;
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) data.push_back(8'($urandom));
        start_session();
        for (int i = 0; i < k; i++) send_word(data[i], 3, 3);
        d = 8'($urandom);
        @(negedge clk);
        bus.data_in = d;
        bus.strobe  = 1'b1;
        bus.load_en = 1'b0;
        cyc = 0;
        while (bus.cpu_hold !== 1'b0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) bus.strobe = 1'b0;
        end
        // The final word's write costs two cycles before LOAD can see load_en low.
        checks++;
        if (cyc != HOLD_LAT + 2) $display("FAIL fall_hold_cycles: got %0d, want %0d", cyc, HOLD_LAT + 2);
        else passes++;
        checks++;
        if (obs.size() != k + 1) $display("FAIL fall_nwrites: got %0d, want %0d", obs.size(), k + 1);
        else passes++;
        if (obs.size() == k + 1) begin
            checks++;
            if (obs[k] !== model_write(k, d))
                $display("FAIL fall_last_write: got %h, want %h", obs[k], model_write(k, d));
            else passes++;
        end
        checks++;
        if ({bus.busy, bus.count} !== {1'b0, 5'(k + 1)})
            $display("FAIL fall_final: busy=%b cnt=%0d, want 0 %0d", bus.busy, bus.count, k + 1);
        else passes++;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] data[$];
        int cyc;
        for (int i = 0; i < 5; i++) data.push_back(8'($urandom));
        start_session();
        run_words(data, 3, 3, "prereset");
        @(negedge clk);
        bus.data_in = 8'($urandom);
        bus.strobe  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_opcode, bus.mem_imm, bus.cpu_hold,
             bus.busy, bus.count, bus.overflow} !== '0)
            $display("FAIL midreset_outputs: we=%b addr=%0d op=%h imm=%h hold=%b busy=%b cnt=%0d ovf=%b, want all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_opcode, bus.mem_imm, bus.cpu_hold,
                     bus.busy, bus.count, bus.overflow);
        else passes++;
        bus.load_en = 1'b0;
        bus.strobe  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) send_word(8'($urandom), 3, 3);
        repeat (6) @(negedge clk);
        checks++;
        if (obs.size() != 5) $display("FAIL midreset_no_write: got %0d writes, want 5", obs.size());
        else passes++;
        data.delete();
        data.push_back(8'($urandom));
        start_session();
        run_words(data, 3, 3, "postreset");
        end_session(cyc);
    endtask

    initial begin
        bus.load_en = 1'b0;
        bus.strobe  = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_basic_load();
        test_random_session();
        test_overflow();
        test_back_to_back();
        test_load_en_fall_in_write();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
